run3_scan_ctrl: RTL and testbench

//   Frame-level scheduler for the three-consecutive-1s detector datapath. Accepts a frame of

---
 rtl/run3_scan_ctrl_if.sv | 28 ++
 rtl/run3_scan_ctrl.sv | 124 ++++++++++++
 tb/tb_run3_scan_ctrl.sv | 318 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/run3_scan_ctrl_if.sv
// Stream and control bundle for the three-consecutive-1s frame scanner.
// master = frame source / controller, slave = run3_scan_ctrl.
interface run3_scan_ctrl_if #(
  parameter int LEN_W = 8,
  parameter int CNT_W = 8
);
  logic             start;
  logic             abort;
  logic [LEN_W-1:0] frame_len;
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       in_data;
  logic             busy;
  logic             done;
  logic             found;
  logic [LEN_W-1:0] first_idx;
  logic [CNT_W-1:0] hit_cnt;

  modport master (
    output start, abort, frame_len, in_valid, in_data,
    input  in_ready, busy, done, found, first_idx, hit_cnt
  );

  modport slave (
    input  start, abort, frame_len, in_valid, in_data,
    output in_ready, busy, done, found, first_idx, hit_cnt
  );
endinterface

// File: rtl/run3_scan_ctrl.sv
// Frame scheduler for the three-consecutive-1s detector: scans frame_len bytes,
// stitching the previous byte's two LSBs in front so runs across byte boundaries are seen.
module run3_scan_ctrl #(
  parameter int LEN_W = 8,
  parameter int CNT_W = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  run3_scan_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic             in_ready;
  logic             busy;
  logic             done;
  logic             found;
  logic [LEN_W-1:0] first_idx;
  logic [CNT_W-1:0] hit_cnt;
  logic [LEN_W-1:0] len;
  logic [LEN_W-1:0] idx;
  logic [1:0]       carry;

  logic [9:0]       window;
  logic             hit;
  logic             accept;

  // bit 9 is oldest: carry[1] precedes carry[0] precedes in_data[7]
  assign window = {carry, bus.in_data};
  assign hit    = |(window[9:2] & window[8:1] & window[7:0]);
  assign accept = bus.in_valid & in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      found     <= 1'b0;
      first_idx <= '0;
      hit_cnt   <= '0;
      len       <= '0;
      idx       <= '0;
      carry     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            found     <= 1'b0;
            first_idx <= '0;
            hit_cnt   <= '0;
            carry     <= '0;
            idx       <= '0;
            len       <= bus.frame_len;
            busy      <= 1'b1;
            if (bus.frame_len != '0) begin
              state    <= SCAN;
              in_ready <= 1'b1;
            end else begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end

        SCAN: begin
          // abort takes priority over a byte handshaken on the same edge
          if (bus.abort) begin
            state     <= IDLE;
            in_ready  <= 1'b0;
            busy      <= 1'b0;
            found     <= 1'b0;
            first_idx <= '0;
            hit_cnt   <= '0;
            carry     <= '0;
            idx       <= '0;
          end else if (accept) begin
            carry <= bus.in_data[1:0];
            if (hit) begin
              if (hit_cnt != '1) hit_cnt <= hit_cnt + CNT_W'(1);
              if (!found) begin
                found     <= 1'b1;
                first_idx <= idx;
              end
            end
            if (idx == len - LEN_W'(1)) begin
              state    <= DONE;
              in_ready <= 1'b0;
              done     <= 1'b1;
            end else begin
              idx <= idx + LEN_W'(1);
            end
          end
        end

        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end

        default: begin
          state    <= IDLE;
          in_ready <= 1'b0;
          busy     <= 1'b0;
          done     <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.busy      = busy;
  assign bus.done      = done;
  assign bus.found     = found;
  assign bus.first_idx = first_idx;
  assign bus.hit_cnt   = hit_cnt;

endmodule

// File: tb/tb_run3_scan_ctrl.sv
// Self-checking bench for run3_scan_ctrl: per-frame expectations from a bit-serial
// reference model are queued at stimulus time and popped when done pulses.
module tb_run3_scan_ctrl;

  logic clk;
  logic rst_n;

  run3_scan_ctrl_if #(.LEN_W(8), .CNT_W(8)) bus ();
  run3_scan_ctrl_if #(.LEN_W(8), .CNT_W(4)) bus4 ();

  run3_scan_ctrl #(.LEN_W(8), .CNT_W(8)) dut  (.clk(clk), .rst_n(rst_n), .bus(bus));
  run3_scan_ctrl #(.LEN_W(8), .CNT_W(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       found;
    logic [7:0] first_idx;
    logic [7:0] hit_cnt;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] fb[256];
  int         checks = 0;
  int         errors = 0;

  // Reference: walk each bit in time order tracking the current run of 1s.
  function automatic exp_t model(input int n, input int cnt_max);
    exp_t e;
    int   run;
    bit   hit;
    e.found = 1'b0; e.first_idx = '0; e.hit_cnt = '0;
    run = 0;
    for (int b = 0; b < n; b++) begin
      hit = 1'b0;
      for (int i = 7; i >= 0; i--) begin
        run = fb[b][i] ? run + 1 : 0;
        if (run >= 3) hit = 1'b1;
      end
      if (hit) begin
        if (!e.found) begin e.found = 1'b1; e.first_idx = b[7:0]; end
        if (int'(e.hit_cnt) < cnt_max) e.hit_cnt = e.hit_cnt + 8'd1;
      end
    end
    return e;
  endfunction

  task automatic start_frame(input int n, input int gap);
    sb.push_back(model(n, 255));
    @(posedge clk); #1;
    bus.start = 1'b1; bus.frame_len = n[7:0];
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int b = 0; b < n; b++) begin
      if (b > 0) begin
        for (int g = 0; g < gap; g++) begin
          bus.in_valid = 1'b0;
          @(negedge clk);
          checks++;
          if (bus.in_ready !== 1'b1 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL gap_ready byte %0d: in_ready=%b done=%b, required 1/0", b, bus.in_ready, bus.done);
          end
          @(posedge clk); #1;
        end
      end
      bus.in_valid = 1'b1; bus.in_data = fb[b];
      @(negedge clk);
      checks++;
      if (bus.in_ready !== 1'b1) begin
        errors++;
        $display("FAIL scan_ready byte %0d: in_ready=%b, required 1", b, bus.in_ready);
      end
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
    end
  endtask

  task automatic wait_done(input string name);
    int   lat;
    bit   seen;
    exp_t e;
    lat = 0; seen = 1'b0;
    while (!seen && lat < 20) begin
      @(negedge clk);
      lat++;
      if (bus.done === 1'b1) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s_done_timeout: no done within %0d cycles, required done", name, lat);
      if (sb.size() > 0) void'(sb.pop_front());
      return;
    end
    if (lat != 1) begin
      errors++;
      $display("FAIL %s_latency: done after %0d cycles, required 1", name, lat);
    end
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s_unexpected_done: done with empty scoreboard, required no done", name);
      return;
    end
    e = sb.pop_front();
    if (bus.found !== e.found || bus.first_idx !== e.first_idx || bus.hit_cnt !== e.hit_cnt) begin
      errors++;
      $display("FAIL %s_result: found=%b first_idx=%0d hit_cnt=%0d, required %b/%0d/%0d",
               name, bus.found, bus.first_idx, bus.hit_cnt, e.found, e.first_idx, e.hit_cnt);
    end
    @(negedge clk);
    checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.found !== e.found ||
        bus.first_idx !== e.first_idx || bus.hit_cnt !== e.hit_cnt) begin
      errors++;
      $display("FAIL %s_after_done: done=%b busy=%b found=%b idx=%0d cnt=%0d, required 0/0/%b/%0d/%0d",
               name, bus.done, bus.busy, bus.found, bus.first_idx, bus.hit_cnt,
               e.found, e.first_idx, e.hit_cnt);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    checks++;
    if (bus.in_ready !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0 ||
        bus.found !== 1'b0 || bus.first_idx !== 8'd0 || bus.hit_cnt !== 8'd0) begin
      errors++;
      $display("FAIL reset_state: ready=%b busy=%b done=%b found=%b idx=%0d cnt=%0d, required all 0",
               bus.in_ready, bus.busy, bus.done, bus.found, bus.first_idx, bus.hit_cnt);
    end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    fb[0] = 8'hE0;
    start_frame(1, 0);
    wait_done("single");
  endtask

  task automatic test_boundary();
    fb[0] = 8'h03; fb[1] = 8'h80;
    start_frame(2, 0);
    wait_done("boundary");
  endtask

  task automatic test_no_hit();
    fb[0] = 8'h55; fb[1] = 8'hAA; fb[2] = 8'h55;
    start_frame(3, 0);
    wait_done("no_hit");
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (bus.done !== 1'b0) begin
        errors++;
        $display("FAIL no_hit_extra_done: done=%b, required 0", bus.done);
      end
    end
  endtask

  task automatic test_gaps();
    for (int b = 0; b < 4; b++) fb[b] = 8'h07;
    start_frame(4, 2);
    wait_done("gaps");
  endtask

  task automatic test_abort();
    @(posedge clk); #1;
    bus.start = 1'b1; bus.frame_len = 8'd4;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int b = 0; b < 2; b++) begin
      bus.in_valid = 1'b1; bus.in_data = 8'hFF;
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    bus.start = 1'b1; bus.frame_len = 8'd0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b1 || bus.in_ready !== 1'b1 || bus.done !== 1'b0 ||
        bus.found !== 1'b1 || bus.first_idx !== 8'd0 || bus.hit_cnt !== 8'd2) begin
      errors++;
      $display("FAIL start_ignored: busy=%b ready=%b done=%b found=%b idx=%0d cnt=%0d, required 1/1/0/1/0/2",
               bus.busy, bus.in_ready, bus.done, bus.found, bus.first_idx, bus.hit_cnt);
    end
    bus.abort = 1'b1; bus.in_valid = 1'b1; bus.in_data = 8'hFF;
    @(posedge clk); #1;
    bus.abort = 1'b0; bus.in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.in_ready !== 1'b0 || bus.done !== 1'b0 ||
        bus.found !== 1'b0 || bus.first_idx !== 8'd0 || bus.hit_cnt !== 8'd0) begin
      errors++;
      $display("FAIL abort_clear: busy=%b ready=%b done=%b found=%b idx=%0d cnt=%0d, required all 0",
               bus.busy, bus.in_ready, bus.done, bus.found, bus.first_idx, bus.hit_cnt);
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
        errors++;
        $display("FAIL abort_no_done: done=%b busy=%b, required 0/0", bus.done, bus.busy);
      end
    end
    start_frame(0, 0);
    wait_done("zero_len");
  endtask

  task automatic test_back_to_back();
    fb[0] = 8'h03;
    start_frame(1, 0);
    wait_done("b2b_a");
    fb[0] = 8'h80;
    start_frame(1, 0);
    wait_done("b2b_carry_cleared");
    fb[0] = 8'h01; fb[1] = 8'hC0; fb[2] = 8'h0E;
    start_frame(3, 0);
    wait_done("b2b_c");
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    bus.start = 1'b1; bus.frame_len = 8'd5;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.in_valid = 1'b1; bus.in_data = 8'h00;
    @(posedge clk); #1;
    bus.in_data = 8'hE0;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b1 || bus.found !== 1'b1 || bus.first_idx !== 8'd1 || bus.hit_cnt !== 8'd1) begin
      errors++;
      $display("FAIL pre_reset: busy=%b found=%b idx=%0d cnt=%0d, required 1/1/1/1",
               bus.busy, bus.found, bus.first_idx, bus.hit_cnt);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.in_ready !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0 ||
        bus.found !== 1'b0 || bus.first_idx !== 8'd0 || bus.hit_cnt !== 8'd0) begin
      errors++;
      $display("FAIL async_reset: ready=%b busy=%b done=%b found=%b idx=%0d cnt=%0d, required all 0",
               bus.in_ready, bus.busy, bus.done, bus.found, bus.first_idx, bus.hit_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_idle: busy=%b ready=%b, required 0/0", bus.busy, bus.in_ready);
    end
  endtask

  task automatic test_saturation();
    exp_t e;
    int   lat;
    bit   seen;
    for (int b = 0; b < 255; b++) fb[b] = 8'hFF;
    sb.push_back(model(255, 15));
    @(posedge clk); #1;
    bus4.start = 1'b1; bus4.frame_len = 8'd255;
    @(posedge clk); #1;
    bus4.start = 1'b0;
    bus4.in_valid = 1'b1; bus4.in_data = 8'hFF;
    repeat (255) @(posedge clk);
    #1 bus4.in_valid = 1'b0;
    lat = 0; seen = 1'b0;
    while (!seen && lat < 10) begin
      @(negedge clk);
      lat++;
      if (bus4.done === 1'b1) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL sat_done_timeout: no done within %0d cycles, required done", lat);
      if (sb.size() > 0) void'(sb.pop_front());
      return;
    end
    e = sb.pop_front();
    if (bus4.found !== e.found || bus4.first_idx !== e.first_idx || 8'(bus4.hit_cnt) !== e.hit_cnt) begin
      errors++;
      $display("FAIL sat_result: found=%b idx=%0d cnt=%0d, required %b/%0d/%0d",
               bus4.found, bus4.first_idx, bus4.hit_cnt, e.found, e.first_idx, e.hit_cnt);
    end
  endtask

  initial begin
    bus.start = 1'b0; bus.abort = 1'b0; bus.frame_len = '0; bus.in_valid = 1'b0; bus.in_data = '0;
    bus4.start = 1'b0; bus4.abort = 1'b0; bus4.frame_len = '0; bus4.in_valid = 1'b0; bus4.in_data = '0;
    test_reset();
    test_single();
    test_boundary();
    test_no_hit();
    test_gaps();
    test_abort();
    test_back_to_back();
    test_reset_mid();
    test_saturation();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
